sam_stream_tx: RTL and testbench
================================

SAM_STREAM_TX -- requirements
Module: sam_stream_tx

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 8, giving the number of 2-bit kernel elements serialized per frame.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16 (power of two), giving the number of 33-bit entries (word + last flag) in the host FIFO.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port Host_Data, input, 32 bits: word offered by the host.
REQ-006 The block SHALL have port Host_Last, input, 1 bit: marks Host_Data as the final word of a frame.
REQ-007 The block SHALL have port Host_Valid, input, 1 bit: Host_Data/Host_Last are valid.
REQ-008 The block SHALL have port Host_Ready, output, 1 bit: FIFO not full; a push occurs on an edge where Host_Valid and Host_Ready are both 1.
REQ-009 The block SHALL have port Kernel_In, input, 2*KERNEL_SIZE bits: parallel kernel, where element k is Kernel_In[2k+1:2k].
REQ-010 The block SHALL have port Start, input, 1 bit: frame start request.
REQ-011 The block SHALL have port Data_Out, output, 32 bits: streamed word to the convolution core's data input.
REQ-012 The block SHALL have port Kernel_Serial_Output, output, 2 bits: serial kernel to the core's kernel input.
REQ-013 The block SHALL have port Last_Data_Out, output, 1 bit: qualifies the final word on Data_Out.
REQ-014 The block SHALL have port Busy, output, 1 bit: a frame is in progress.
REQ-015 The block SHALL have port Done, output, 1 bit: one-cycle frame completion pulse.
REQ-016 The block SHALL have port Underflow, output, 1 bit: sticky flag, FIFO empty when a word was due.

Function
REQ-017 The block SHALL implement states IDLE, PRELOAD, STREAM and DONE.
REQ-018 In IDLE, Start=1 with the FIFO non-empty SHALL latch Kernel_In, clear Underflow, pop the FIFO head and enter PRELOAD; Start with the FIFO empty SHALL be ignored.
REQ-019 Start SHALL be ignored in PRELOAD, STREAM and DONE.
REQ-020 Every edge in IDLE-accepting-Start, PRELOAD or STREAM SHALL pop one word and register it onto Data_Out, giving one new word per cycle with 1-cycle latency from pop.
REQ-021 PRELOAD SHALL last exactly KERNEL_SIZE cycles, driving element 0 on the first cycle and element k on the (k+1)th, then enter STREAM.
REQ-022 Kernel_Serial_Output SHALL be 0 outside PRELOAD.
REQ-023 Last_Data_Out SHALL be 1 for exactly the cycle in which the word pushed with Host_Last=1 is on Data_Out; the next state SHALL be DONE, even from PRELOAD, aborting the remaining kernel elements.
REQ-024 DONE SHALL last one cycle with Done=1, Data_Out=0 and Last_Data_Out=0, then return to IDLE.
REQ-025 Busy SHALL be 1 in PRELOAD and STREAM, and 0 otherwise.
REQ-026 If a pop is due while the FIFO is empty, Data_Out SHALL be 0, Underflow SHALL set, the frame SHALL continue, and no pointer SHALL change.
REQ-027 Host_Ready SHALL equal NOT full, combinationally from the FIFO count.
REQ-028 A push with Host_Ready=0 SHALL be ignored.
REQ-029 Simultaneous push and pop SHALL be allowed when the FIFO is non-empty and not full, and the count SHALL be unchanged.
REQ-030 A push to an empty FIFO in the same cycle as a due pop SHALL store the word with no bypass, and Underflow SHALL set.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be FIFO_DEPTH when full.
REQ-032 Words pushed after a Host_Last word SHALL remain queued for the next frame.
REQ-033 Data SHALL pass unmodified, with no arithmetic and no width change.

Reset
REQ-034 Rst=0 SHALL immediately force IDLE, empty the FIFO, and set Data_Out=0, Kernel_Serial_Output=0, Last_Data_Out=0, Busy=0, Done=0 and Underflow=0; Host_Ready SHALL then read 1.
REQ-035 Reset asserted mid-frame SHALL discard the frame and the FIFO contents with no Done pulse; operation SHALL resume on the first edge after Rst returns to 1.

Verification
REQ-036 Basic frame: KERNEL_SIZE=8, Kernel_In=16'hE4E4, push words 1..12 with last on 12, then Start -> Data_Out 1..12 on consecutive cycles, Kernel_Serial_Output 0,1,2,3,0,1,2,3, then 0, Last_Data_Out with 12, Done next cycle.
REQ-037 Short frame: push 3 words, last on 3, then Start -> Last_Data_Out with word 3 during PRELOAD cycle 3, then DONE, and Kernel_Serial_Output returns to 0.
REQ-038 Full FIFO: push 17 words with FIFO_DEPTH=16 -> Host_Ready low after the 16th, 17th word dropped, Host_Ready high again after the first pop.
REQ-039 Underflow: push words 1..4 (no last), Start -> cycles 5 onward show Data_Out=0 and Underflow=1; a later push of 9 with last -> 9 appears with Last_Data_Out.
REQ-040 Start with the FIFO empty, and Start during STREAM -> no state change.
REQ-041 Async reset asserted between edges in STREAM -> all outputs 0 and Host_Ready=1 immediately; a new frame afterwards runs as in REQ-036.

Source files
------------

// File: rtl/sam_stream_tx.sv
// Host-to-convolution-core streamer: buffers host words in a FIFO,
// serializes the kernel during PRELOAD and streams one word per cycle.
module sam_stream_tx #(
  parameter int KERNEL_SIZE = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [31:0]              Host_Data,
  input  logic                     Host_Last,
  input  logic                     Host_Valid,
  output logic                     Host_Ready,
  input  logic [2*KERNEL_SIZE-1:0] Kernel_In,
  input  logic                     Start,
  output logic [31:0]              Data_Out,
  output logic [1:0]               Kernel_Serial_Output,
  output logic                     Last_Data_Out,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(KERNEL_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRELOAD,
    STREAM,
    DONE
  } state_t;

  state_t                   state_q;
  logic [32:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]            rd_q, wr_q;
  logic [CW-1:0]            cnt_q;
  logic [31:0]              data_q;
  logic                     last_q;
  logic [1:0]               kso_q;
  logic [KW-1:0]            k_q;
  logic [2*KERNEL_SIZE-1:0] kern_q;
  logic                     busy_q, done_q, under_q;

  logic        empty, full, push, pop_due, pop, under;
  logic [32:0] head;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(FIFO_DEPTH));
    push    = Host_Valid && !full;
    head    = mem_q[rd_q];
    pop_due = 1'b0;
    unique case (state_q)
      IDLE:            pop_due = Start && !empty;
      PRELOAD, STREAM: pop_due = !last_q;
      default:         pop_due = 1'b0;
    endcase
    pop   = pop_due && !empty;
    under = pop_due && empty;
  end

  // Storage carries no reset; emptiness lives in the pointers and count.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q] <= {Host_Last, Host_Data};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      kso_q   <= '0;
      k_q     <= '0;
      kern_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (pop_due) begin
        data_q <= pop ? head[31:0] : '0;
        last_q <= pop && head[32];
      end
      if (under) under_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (Start && !empty) begin
            state_q <= PRELOAD;
            busy_q  <= 1'b1;
            kern_q  <= Kernel_In;
            kso_q   <= Kernel_In[1:0];
            k_q     <= KW'(1);
            under_q <= 1'b0;
          end
        end
        PRELOAD, STREAM: begin
          if (last_q) begin
            // Final word already presented: abort any kernel remainder.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kso_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
          end else if (state_q == PRELOAD) begin
            if (k_q == KW'(KERNEL_SIZE)) begin
              state_q <= STREAM;
              kso_q   <= '0;
            end else begin
              kso_q <= kern_q[{k_q, 1'b0} +: 2];
              k_q   <= k_q + KW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Host_Ready           = !full;
  assign Data_Out             = data_q;
  assign Kernel_Serial_Output = kso_q;
  assign Last_Data_Out        = last_q;
  assign Busy                 = busy_q;
  assign Done                 = done_q;
  assign Underflow            = under_q;

endmodule

// File: tb/tb_sam_stream_tx.sv
// Directed and randomized frames for sam_stream_tx, checked against
// a queue-based model of the host FIFO and the frame timing rules.
module tb_sam_stream_tx;

  localparam int K = 8;
  localparam int D = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Host_Data = '0;
  logic        Host_Last = 1'b0;
  logic        Host_Valid = 1'b0;
  logic        Host_Ready;
  logic [15:0] Kernel_In = '0;
  logic        Start = 1'b0;
  logic [31:0] Data_Out;
  logic [1:0]  Kernel_Serial_Output;
  logic        Last_Data_Out;
  logic        Busy;
  logic        Done;
  logic        Underflow;

  sam_stream_tx #(.KERNEL_SIZE(K), .FIFO_DEPTH(D)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Host_Data(Host_Data),
    .Host_Last(Host_Last),
    .Host_Valid(Host_Valid),
    .Host_Ready(Host_Ready),
    .Kernel_In(Kernel_In),
    .Start(Start),
    .Data_Out(Data_Out),
    .Kernel_Serial_Output(Kernel_Serial_Output),
    .Last_Data_Out(Last_Data_Out),
    .Busy(Busy),
    .Done(Done),
    .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passes = 0;
  logic [32:0] q[$];

  function automatic logic [1:0] kel(input logic [15:0] kern, input int i);
    logic [15:0] t;
    t = kern >> (2 * i);
    return t[1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d,
                         input logic l, input logic [1:0] k,
                         input logic b, input logic dn, input logic u);
    chk({tag, ":data"}, Data_Out, d);
    chk({tag, ":last"}, 32'(Last_Data_Out), 32'(l));
    chk({tag, ":kso"}, 32'(Kernel_Serial_Output), 32'(k));
    chk({tag, ":busy"}, 32'(Busy), 32'(b));
    chk({tag, ":done"}, 32'(Done), 32'(dn));
    chk({tag, ":uflow"}, 32'(Underflow), 32'(u));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    bit acc;
    acc = (q.size() < D);
    Host_Valid = 1'b1;
    Host_Data  = d;
    Host_Last  = l;
    chk("push:ready", 32'(Host_Ready), 32'(acc));
    step();
    if (acc) q.push_back({l, d});
    Host_Valid = 1'b0;
    Host_Last  = 1'b0;
  endtask

  // Frame = FIFO words up to and including the first last-flagged one.
  task automatic run_frame(input logic [15:0] kern, input bit rnd_push,
                           input bit hold_start, input string tag);
    logic [32:0] e;
    bit pv;
    bit fin;
    fin = 1'b0;
    Kernel_In = kern;
    Start = 1'b1;
    for (int i = 0; i < 40 && !fin; i++) begin
      pv = rnd_push && (q.size() < 12) && ($urandom_range(0, 1) == 1);
      Host_Valid = pv;
      Host_Data  = $urandom;
      Host_Last  = 1'b0;
      chk({tag, ":ready"}, 32'(Host_Ready), 32'(q.size() < D));
      step();
      e = q.pop_front();
      if (pv) q.push_back({1'b0, Host_Data});
      if (!hold_start) Start = 1'b0;
      Kernel_In = 16'($urandom);
      chk_out(tag, e[31:0], e[32], (i < K) ? kel(kern, i) : 2'b00,
              1'b1, 1'b0, 1'b0);
      fin = e[32];
    end
    Host_Valid = 1'b0;
    Start = 1'b0;
    chk({tag, ":ended"}, 32'(fin), 32'd1);
    step();
    chk_out({tag, ":donecyc"}, '0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    chk_out({tag, ":idlecyc"}, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_basic();
    for (int w = 1; w <= 12; w++) push_word(32'(w), w == 12);
  endtask

  initial begin
    logic [15:0] kr;
    int n;

    #3;
    chk_out("reset", '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("reset:ready", 32'(Host_Ready), 32'd1);
    step();
    Rst = 1'b1;

    Start = 1'b1;
    step();
    chk_out("start_empty", '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("start_empty2", '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    Start = 1'b0;

    push_basic();
    run_frame(16'hE4E4, 1'b0, 1'b1, "basic");

    for (int w = 1; w <= 3; w++) push_word(32'(w + 40), w == 3);
    run_frame(16'h1B6C, 1'b0, 1'b0, "short");

    for (int w = 1; w <= 16; w++) push_word(32'(w + 100), w == 16);
    chk("full:ready", 32'(Host_Ready), 32'd0);
    push_word(32'd999, 1'b1);
    run_frame(16'($urandom), 1'b0, 1'b0, "full");

    kr = 16'($urandom);
    for (int w = 1; w <= 4; w++) push_word(32'(w), 1'b0);
    Kernel_In = kr;
    Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      Start = 1'b0;
      chk_out("uflow", (i < 4) ? 32'(i + 1) : 32'd0, 1'b0,
              (i < K) ? kel(kr, i) : 2'b00, 1'b1, 1'b0, i >= 4);
    end
    Host_Valid = 1'b1;
    Host_Data  = 32'd9;
    Host_Last  = 1'b1;
    step();
    Host_Valid = 1'b0;
    Host_Last  = 1'b0;
    chk_out("uflow_push", '0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("uflow_nine", 32'd9, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("uflow_done", '0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("uflow_idle", '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    push_basic();
    Kernel_In = 16'hE4E4;
    Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      Start = 1'b0;
    end
    chk("midrst:busy", 32'(Busy), 32'd1);
    chk("midrst:data", Data_Out, 32'd10);
    #2;
    Rst = 1'b0;
    #1;
    chk_out("midrst", '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("midrst:ready", 32'(Host_Ready), 32'd1);
    q.delete();
    step();
    Rst = 1'b1;
    push_basic();
    run_frame(16'hE4E4, 1'b0, 1'b0, "after_rst");

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 15 - q.size());
      for (int w = 1; w <= n; w++) push_word($urandom, w == n);
      run_frame(16'($urandom), 1'b1, f[0], $sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
